// File: rtl/cpu_sequencer.sv
// Purpose: arbitrates the single RAM port between the host loader and the cpuv2 core, and boots, stops and times core runs.
// Latency: WRITE takes 2 cycles from accept to ready; READ gives rsp_valid 3 cycles after accept; RUN releases cpu_reset 2 cycles after accept.
// Backpressure: cmd_ready is high only in IDLE and RUN. Commands other than STOP that arrive during RUN are consumed and answered with cmd_error.
module cpu_sequencer #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    // host command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [7:0]            cmd_data,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_data,
    output logic                  cmd_error,
    output logic                  running,
    output logic                  done,
    output logic [31:0]           run_cycles,
    // core control and memory request
    output logic                  cpu_reset,
    output logic                  cpu_halt,
    output logic [addr_width-1:0] cpu_start_address,
    input  logic                  cpu_halted,
    input  logic [addr_width-1:0] cpu_raddr,
    input  logic [addr_width-1:0] cpu_waddr,
    input  logic                  cpu_write,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    // RAM port
    output logic [addr_width-1:0] mem_raddr,
    output logic [addr_width-1:0] mem_waddr,
    output logic                  mem_write,
    output logic [7:0]            mem_data_in,
    input  logic [7:0]            mem_data_out
);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ1,
        S_READ2,
        S_READ3,
        S_BOOT,
        S_RUN,
        S_STOPPING
    } state_t;

    state_t state, state_next;
    logic   ready_st;
    logic   cmd_fire;
    logic   core_owns;

    logic [addr_width-1:0] host_raddr;
    logic [addr_width-1:0] host_waddr;
    logic [7:0]            host_wdata;
    logic [addr_width-1:0] start_addr;

    // Commands are held off while the reset is asserted so that nothing is latched during an abort.
    assign cmd_ready = ready_st & ~reset;
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign core_owns = (state == S_RUN) || (state == S_STOPPING);

    assign running           = core_owns;
    assign cpu_reset         = reset | ~core_owns;
    assign cpu_halt          = (state == S_STOPPING);
    assign cpu_start_address = start_addr;
    assign cpu_rdata         = mem_data_out;

    // RAM port mux: the core drives it in RUN and STOPPING, and the host registers drive it otherwise.
    // A stray write request from the core is suppressed while the host owns the port.
    assign mem_raddr   = core_owns ? cpu_raddr : host_raddr;
    assign mem_waddr   = core_owns ? cpu_waddr : host_waddr;
    assign mem_data_in = core_owns ? cpu_wdata : host_wdata;
    assign mem_write   = core_owns ? cpu_write : (state == S_WRITE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic and per-state command readiness
    always_comb begin
        state_next = state;
        ready_st   = 1'b0;
        case (state)
            S_IDLE: begin
                ready_st = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: state_next = S_WRITE;
                        OP_READ:  state_next = S_READ1;
                        OP_RUN:   state_next = S_BOOT;
                        default:  state_next = S_IDLE;
                    endcase
                end
            end
            S_WRITE: state_next = S_IDLE;
            S_READ1: state_next = S_READ2;
            S_READ2: state_next = S_READ3;
            S_READ3: state_next = S_IDLE;
            S_BOOT:  state_next = S_RUN;
            S_RUN: begin
                ready_st = 1'b1;
                // A halt instruction takes priority over a STOP that arrives in the same cycle.
                if (cpu_halted)
                    state_next = S_IDLE;
                else if (cmd_valid && cmd_op == OP_STOP)
                    state_next = S_STOPPING;
            end
            S_STOPPING: begin
                if (cpu_halted) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Host registers, response capture, error pulse, done flag and run-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            host_raddr <= '0;
            host_waddr <= '0;
            host_wdata <= '0;
            start_addr <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            cmd_error  <= 1'b0;
            done       <= 1'b0;
            run_cycles <= '0;
        end else begin
            rsp_valid <= 1'b0;
            cmd_error <= 1'b0;

            if (state == S_IDLE && cmd_fire) begin
                case (cmd_op)
                    OP_WRITE: begin
                        host_waddr <= cmd_addr;
                        host_wdata <= cmd_data;
                    end
                    OP_READ: host_raddr <= cmd_addr;
                    OP_RUN: begin
                        start_addr <= cmd_addr;
                        done       <= 1'b0;
                        run_cycles <= '0;
                    end
                    default: ;
                endcase
            end

            // The RAM output reflects the address presented in READ1 during READ2, so capture it here and present it in READ3.
            if (state == S_READ2) begin
                rsp_data  <= mem_data_out;
                rsp_valid <= 1'b1;
            end

            if (state == S_RUN && cmd_fire && cmd_op != OP_STOP)
                cmd_error <= 1'b1;

            if (core_owns && run_cycles != 32'hFFFF_FFFF)
                run_cycles <= run_cycles + 32'd1;

            if (state == S_RUN && cpu_halted)
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Purpose: directed checks of cpu_sequencer host access, boot, halt, stop, error and reset-abort behaviour.
// Latency: the bench applies inputs 1 ns after each rising edge and samples outputs at that same point.
// Backpressure: each command is issued only after cmd_ready has been checked high.
module tb_cpu_sequencer;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        cmd_error;
    logic        running;
    logic        done;
    logic [31:0] run_cycles;
    logic        cpu_reset;
    logic        cpu_halt;
    logic [8:0]  cpu_start_address;
    logic        cpu_halted;
    logic [8:0]  cpu_raddr;
    logic [8:0]  cpu_waddr;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [8:0]  mem_raddr;
    logic [8:0]  mem_waddr;
    logic        mem_write;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ram [0:511];

    cpu_sequencer #(.addr_width(9)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .cmd_error(cmd_error),
        .running(running), .done(done), .run_cycles(run_cycles),
        .cpu_reset(cpu_reset), .cpu_halt(cpu_halt), .cpu_start_address(cpu_start_address),
        .cpu_halted(cpu_halted), .cpu_raddr(cpu_raddr), .cpu_waddr(cpu_waddr),
        .cpu_write(cpu_write), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_write(mem_write),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data for the address presented in one cycle appears in the next.
    always @(posedge clk) begin
        if (mem_write) ram[mem_waddr] <= mem_data_in;
        mem_data_out <= ram[mem_raddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a command in the current cycle; on return the bench is in the cycle after acceptance.
    task automatic send(input logic [1:0] op, input logic [8:0] a, input logic [7:0] d);
        check("send_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [8:0] a, input logic [7:0] d);
        send(OP_WRITE, a, d);
        check("wr_we_t1", mem_write, 1);
        check("wr_waddr", mem_waddr, a);
        check("wr_wdata", mem_data_in, d);
        check("wr_busy", cmd_ready, 0);
        tick;
        check("wr_we_t2", mem_write, 0);
        check("wr_ready_t2", cmd_ready, 1);
    endtask

    task automatic do_read(input logic [8:0] a, input logic [7:0] exp);
        send(OP_READ, a, 8'h00);
        check("rd_raddr", mem_raddr, a);
        check("rd_vld_t1", rsp_valid, 0);
        tick;
        check("rd_vld_t2", rsp_valid, 0);
        tick;
        check("rd_vld_t3", rsp_valid, 1);
        check("rd_data", rsp_data, exp);
        check("rd_busy_t3", cmd_ready, 0);
        tick;
        check("rd_vld_t4", rsp_valid, 0);
        check("rd_ready_t4", cmd_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 8'h00;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0;
        cpu_halted = 1'b0; cpu_raddr = 9'h033; cpu_waddr = '0; cpu_write = 1'b0; cpu_wdata = '0;
        tick; tick;

        // reset values
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_cmd_error", cmd_error, 0);
        check("rst_run_cycles", run_cycles, 0);
        check("rst_cpu_halt", cpu_halt, 0);
        check("rst_mem_write", mem_write, 0);
        reset = 1'b0;
        tick;
        check("idle_ready", cmd_ready, 1);

        // host write and read-back, including the top address
        do_write(9'h005, 8'h12);
        do_read(9'h005, 8'h12);
        do_write(9'h1FF, 8'hA5);
        do_read(9'h1FF, 8'hA5);

        // STOP while idle is a silent no-op
        send(OP_STOP, 9'h000, 8'h00);
        check("stop_idle_err", cmd_error, 0);
        check("stop_idle_ready", cmd_ready, 1);
        check("stop_idle_halt", cpu_halt, 0);

        // core write request while the host owns the port is suppressed
        cpu_write = 1'b1; cpu_waddr = 9'h005; cpu_wdata = 8'hEE;
        #1;
        check("host_owns_we", mem_write, 0);
        tick;
        cpu_write = 1'b0;

        // program ending in 0xFFFF; run from 0 and halt after five RUN cycles
        do_write(9'h000, 8'hFF);
        do_write(9'h001, 8'hFF);
        send(OP_RUN, 9'h000, 8'h00);                       // T+1: BOOT
        check("boot_cpu_reset", cpu_reset, 1);
        check("boot_running", running, 0);
        check("boot_busy", cmd_ready, 0);
        tick;                                              // T+2: RUN
        check("run_cpu_reset", cpu_reset, 0);
        check("run_running", running, 1);
        check("run_core_raddr", mem_raddr, 9'h033);
        check("run_cycles_0", run_cycles, 0);
        tick;                                              // T+3
        check("run_cycles_1", run_cycles, 1);
        tick; tick; tick;                                  // T+6: halt seen
        cpu_halted = 1'b1;
        tick;                                              // T+7
        cpu_halted = 1'b0;
        check("halt_done", done, 1);
        check("halt_running", running, 0);
        check("halt_cpu_reset", cpu_reset, 1);
        check("halt_run_cycles", run_cycles, 5);
        check("halt_err", cmd_error, 0);
        do_read(9'h005, 8'h12);                            // accepted in the first idle cycle

        // looping program: core writes, rejected host commands, then STOP
        send(OP_RUN, 9'h0A0, 8'h00);                       // T+1
        check("boot_start_addr", cpu_start_address, 9'h0A0);
        check("boot_done_clr", done, 0);
        tick;                                              // T+2
        cpu_write = 1'b1; cpu_waddr = 9'h040; cpu_wdata = 8'h5C;
        #1;
        check("core_we", mem_write, 1);
        check("core_waddr", mem_waddr, 9'h040);
        tick;                                              // T+3
        cpu_write = 1'b0;
        send(OP_READ, 9'h005, 8'h00);                      // T+4
        check("run_read_err", cmd_error, 1);
        check("run_read_norsp", rsp_valid, 0);
        send(OP_WRITE, 9'h005, 8'h99);                     // T+5
        check("run_write_err", cmd_error, 1);
        check("run_write_we", mem_write, 0);
        tick;                                              // T+6
        check("run_err_pulse", cmd_error, 0);
        send(OP_STOP, 9'h000, 8'h00);                      // T+7: STOPPING
        check("stop_halt_t1", cpu_halt, 1);
        check("stop_busy", cmd_ready, 0);
        check("stop_running", running, 1);
        tick;                                              // T+8
        check("stop_halt_t2", cpu_halt, 1);
        cpu_halted = 1'b1;
        tick;                                              // T+9: IDLE
        cpu_halted = 1'b0;
        check("stopped_halt", cpu_halt, 0);
        check("stopped_cpu_reset", cpu_reset, 1);
        check("stopped_done", done, 0);
        check("stopped_cycles", run_cycles, 7);
        do_read(9'h040, 8'h5C);
        do_read(9'h005, 8'h12);

        // reset during READ2 aborts the read
        send(OP_READ, 9'h1FF, 8'h00);                      // T+1
        tick;                                              // T+2: READ2
        reset = 1'b1;
        tick;
        check("rdabort_vld", rsp_valid, 0);
        check("rdabort_cpu_reset", cpu_reset, 1);
        reset = 1'b0;
        tick;
        check("rdabort_vld2", rsp_valid, 0);
        check("rdabort_data", rsp_data, 0);
        check("rdabort_raddr", mem_raddr, 0);
        check("rdabort_ready", cmd_ready, 1);

        // reset during RUN
        send(OP_RUN, 9'h0A0, 8'h00);
        tick; tick;                                        // RUN, two cycles in
        reset = 1'b1;
        tick;
        check("runabort_running", running, 0);
        check("runabort_cpu_reset", cpu_reset, 1);
        check("runabort_cycles", run_cycles, 0);
        check("runabort_start", cpu_start_address, 0);
        reset = 1'b0;
        tick;
        check("runabort_ready", cmd_ready, 1);

        // STOP and halt in the same cycle: halt wins
        send(OP_RUN, 9'h000, 8'h00);                       // T+1
        tick;                                              // T+2: RUN
        cpu_halted = 1'b1;
        send(OP_STOP, 9'h000, 8'h00);                      // T+3
        cpu_halted = 1'b0;
        check("race_done", done, 1);
        check("race_err", cmd_error, 0);
        check("race_halt", cpu_halt, 0);
        check("race_running", running, 0);
        check("race_cycles", run_cycles, 1);
        check("race_ready", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
